text_cell_dpram: RTL and testbench
==================================

Name: text_cell_dpram

Overview:
- Single-clock, true dual-port, byte-writable 64-bit RAM holding text-screen cells; one cell per word.
- Port A is the bus/CPU side, with a 2-cycle registered read. Port B is the video-fetch side, with a 1-cycle read.
- Inferred as block RAM; contents are not reset. Sits between the text controller's bus interface and its display fetch pipeline.

Parameters:
- CELL_COUNT, 16384, number of 64-bit words; must be a power of two.
- AWID, $clog2(CELL_COUNT) = 14, address width (localparam, derived).
- DWID, 64, data width; fixed, multiple of 8.
- NSEL, DWID/8 = 8, byte-enable count (localparam, derived).

Ports:
- clk_i  in  1  sole clock; both ports are synchronous to its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- ena_i  in  1  port A enable; a read or write happens only when high.
- wea_i  in  NSEL  port A byte write enables; bit n writes dina_i[8n+7:8n].
- addra_i  in  AWID  port A word address.
- dina_i  in  DWID  port A write data.
- regcea_i  in  1  port A output-register clock enable.
- douta_o  out  DWID  port A read data, latency 2.
- enb_i  in  1  port B enable.
- web_i  in  NSEL  port B byte write enables.
- addrb_i  in  AWID  port B word address.
- dinb_i  in  DWID  port B write data.
- doutb_o  out  DWID  port B read data, latency 1.

Behaviour:
- Array: CELL_COUNT x DWID. Initial contents are all zero (simulation init and bitstream). Never cleared by reset.
- Reset:
  - rst_ni low asynchronously clears the port A stage-1 register, douta_o and doutb_o to 0.
  - While rst_ni is low, no writes or reads occur.
  - On the first rising edge after deassertion, normal operation resumes.
- Port A write: at an edge with ena_i=1 and wea_i!=0, the enabled bytes of mem[addra_i] are updated from dina_i. No-change mode: the stage-1 register holds its value.
- Port A read, in two stages:
  - Edge k, with ena_i=1 and wea_i==0: stage-1 captures mem[addra_i] (pre-write contents).
  - Edge k+1, with regcea_i=1: douta_o is loaded from stage-1.
  - regcea_i=0 holds douta_o. ena_i=0 holds stage-1.
- Port B write: at an edge with enb_i=1 and web_i!=0, the enabled bytes of mem[addrb_i] are updated. doutb_o holds (no-change).
- Port B read: at an edge with enb_i=1 and web_i==0, doutb_o gets mem[addrb_i]. Valid after that single edge. enb_i=0 holds doutb_o.
- Collisions (same address, same edge):
  - Both ports write: merge per byte. A byte enabled on only one port takes that port's data. A byte enabled on both ports takes port B's data.
  - One port reads while the other writes: the reader gets the OLD contents (read-first across ports). The new data is visible from the next read.
- Addresses are always in range; no wrap logic beyond AWID bits.
- No handshake or backpressure. Every enabled operation completes in one cycle.

Optional Feature:
- Macro TDPRAM_COLLISION_FLAG_EN.
- When defined:
  - Extra output coll_o (1 bit) is added; it resets to 0.
  - coll_o is registered high for exactly one cycle after an edge where ena_i=1, enb_i=1, addra_i==addrb_i and (wea_i!=0 or web_i!=0).
  - A simulation $warning is issued on the same edge.
- When undefined:
  - The port and the logic are absent.
  - Data behaviour is identical in both builds.

Decomposition:
- Package text_cell_pkg holds:
  - DWID and the byte width 8.
  - typedef cell_word_t (logic [63:0]) and typedef cell_sel_t (logic [7:0]).
  - The default CELL_COUNT.
- One natural sub-module: text_cell_wport, a byte-masked write-merge helper (old word, new word, sel -> merged word). It is instantiated for port A and port B, and port B's result is applied last to give B priority.
- The array and output registers stay in the top module.

Test Plan:
- Reset and initial value: assert rst_ni=0 mid-operation -> douta_o=0 and doutb_o=0 immediately. After release, a read of address 0 returns 64'h0 on both ports.
- Port A write then read:
  - Write 64'h0123_4567_89AB_CDEF to address 5 with wea_i=8'hFF.
  - Read address 5 with regcea_i=1 -> douta_o equals the word exactly 2 edges after the read edge, and is unchanged after 1 edge.
- Byte-enable merge:
  - Memory 5 = 64'h0123_4567_89AB_CDEF. Port B writes 64'hFFFF_FFFF_FFFF_FFFF with web_i=8'h0F.
  - Port B read of address 5 -> doutb_o = 64'h0123_4567_FFFF_FFFF after 1 edge.
- Cross-port read-first:
  - Memory 0x3FFF = 64'h11. On the same edge, A writes 64'h22 to 0x3FFF and B reads 0x3FFF -> doutb_o = 64'h11.
  - Next B read -> 64'h22.
- Dual-write collision:
  - Memory 7 = 0. On the same edge, A writes 64'hAAAA_AAAA_AAAA_AAAA with sel 8'hF0 and B writes 64'hBBBB_BBBB_BBBB_BBBB with sel 8'h30 to address 7.
  - Read of address 7 -> 64'hAAAA_BBBB_0000_0000. With TDPRAM_COLLISION_FLAG_EN, coll_o pulses for one cycle.
- Enable and hold:
  - After a read, drop ena_i/enb_i and change the addresses -> outputs hold.
  - Write on A with ena_i=1 -> douta_o unchanged (no-change).
  - regcea_i=0 on the second stage -> douta_o keeps its old value.

Source files
------------

// File: rtl/text_cell_pkg.sv
// Shared types and sizing for the text-cell dual-port RAM.
// Cells are 64-bit words, byte-writable through an 8-bit select.
package text_cell_pkg;

  localparam int DWID          = 64;
  localparam int BYTE_W        = 8;
  localparam int NSEL          = DWID / BYTE_W;
  localparam int TC_CELL_COUNT = 16384;

  typedef logic [DWID-1:0] cell_word_t;
  typedef logic [NSEL-1:0] cell_sel_t;

endpackage

// File: rtl/text_cell_wport.sv
// Byte-masked write merge: each selected byte comes from new_i, the rest from old_i.
// Purely combinational; used once per RAM port.
module text_cell_wport
  import text_cell_pkg::*;
(
  input  logic [DWID-1:0] old_i,
  input  logic [DWID-1:0] new_i,
  input  logic [NSEL-1:0] sel_i,
  output logic [DWID-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int n = 0; n < NSEL; n++) begin
      if (sel_i[n]) merged_o[n*BYTE_W +: BYTE_W] = new_i[n*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/text_cell_dpram.sv
// True dual-port byte-writable text-cell RAM: port A (bus) 2-cycle read, port B (video) 1-cycle read.
// Optional collision pulse output coll_o when TDPRAM_COLLISION_FLAG_EN is defined.
module text_cell_dpram
  import text_cell_pkg::*;
#(
  parameter  int CELL_COUNT = TC_CELL_COUNT,
  localparam int AWID       = $clog2(CELL_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ena_i,
  input  logic [NSEL-1:0] wea_i,
  input  logic [AWID-1:0] addra_i,
  input  logic [DWID-1:0] dina_i,
  input  logic            regcea_i,
  output logic [DWID-1:0] douta_o,
  input  logic            enb_i,
  input  logic [NSEL-1:0] web_i,
  input  logic [AWID-1:0] addrb_i,
  input  logic [DWID-1:0] dinb_i,
  output logic [DWID-1:0] doutb_o
`ifdef TDPRAM_COLLISION_FLAG_EN
  ,
  output logic            coll_o
`endif
);

  logic [DWID-1:0] mem_q [CELL_COUNT] = '{default: '0};

  logic [DWID-1:0] stage1_q;
  logic [DWID-1:0] douta_q;
  logic [DWID-1:0] doutb_q;

  logic            wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [DWID-1:0] mrg_a, mrg_b, old_b;

  assign wr_a      = ena_i & (|wea_i);
  assign wr_b      = enb_i & (|web_i);
  assign rd_a      = ena_i & ~(|wea_i);
  assign rd_b      = enb_i & ~(|web_i);
  assign same_addr = (addra_i == addrb_i);

  // B merges on top of A's result when both write one cell, so B wins shared bytes.
  assign old_b = (wr_a && same_addr) ? mrg_a : mem_q[addrb_i];

  text_cell_wport u_wport_a (
    .old_i    (mem_q[addra_i]),
    .new_i    (dina_i),
    .sel_i    (wea_i),
    .merged_o (mrg_a)
  );

  text_cell_wport u_wport_b (
    .old_i    (old_b),
    .new_i    (dinb_i),
    .sel_i    (web_i),
    .merged_o (mrg_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (wr_a) mem_q[addra_i] <= mrg_a;
      if (wr_b) mem_q[addrb_i] <= mrg_b;
    end
  end

  // Reads sample the array before this edge's writes land: read-first across ports.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= '0;
      douta_q  <= '0;
      doutb_q  <= '0;
    end else begin
      if (rd_a)     stage1_q <= mem_q[addra_i];
      if (regcea_i) douta_q  <= stage1_q;
      if (rd_b)     doutb_q  <= mem_q[addrb_i];
    end
  end

  assign douta_o = douta_q;
  assign doutb_o = doutb_q;

`ifdef TDPRAM_COLLISION_FLAG_EN
  logic coll_d, coll_q;

  assign coll_d = ena_i & enb_i & same_addr & ((|wea_i) | (|web_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
      if (coll_d) $warning("text_cell_dpram: port collision at address %0h", addra_i);
    end
  end

  assign coll_o = coll_q;
`endif

endmodule

// File: tb/tb_text_cell_dpram.sv
// Scoreboard bench for text_cell_dpram: stimulus pushes expected outputs with a due cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_text_cell_dpram;
  import text_cell_pkg::*;

  localparam int AW = 14;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            ena_i, enb_i, regcea_i;
  logic [NSEL-1:0] wea_i, web_i;
  logic [AW-1:0]   addra_i, addrb_i;
  logic [DWID-1:0] dina_i, dinb_i, douta_o, doutb_o;
`ifdef TDPRAM_COLLISION_FLAG_EN
  logic            coll_o;
`endif

  text_cell_dpram dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ena_i    (ena_i),
    .wea_i    (wea_i),
    .addra_i  (addra_i),
    .dina_i   (dina_i),
    .regcea_i (regcea_i),
    .douta_o  (douta_o),
    .enb_i    (enb_i),
    .web_i    (web_i),
    .addrb_i  (addrb_i),
    .dinb_i   (dinb_i),
    .doutb_o  (doutb_o)
`ifdef TDPRAM_COLLISION_FLAG_EN
    ,
    .coll_o   (coll_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [DWID-1:0] val;
    int              tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int tag, input logic [DWID-1:0] got,
                     input logic [DWID-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s tag=%0d got=%h want=%h (cycle %0d)", name, tag, got, want, cyc);
    end
  endtask

  task automatic drain(inout exp_t q[$], input string name, input logic [DWID-1:0] got);
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s tag=%0d missed due=%0d now=%0d", name, e.tag, e.due, cyc);
      end else begin
        chk(name, e.tag, got, e.val);
      end
    end
  endtask

  always @(negedge clk_i) begin
    drain(qa, "douta", douta_o);
    drain(qb, "doutb", doutb_o);
`ifdef TDPRAM_COLLISION_FLAG_EN
    drain(qc, "coll", {{(DWID-1){1'b0}}, coll_o});
`endif
  end

  task automatic expa(input int dly, input logic [DWID-1:0] v, input int tag);
    qa.push_back('{due: cyc + dly, val: v, tag: tag});
  endtask
  task automatic expb(input int dly, input logic [DWID-1:0] v, input int tag);
    qb.push_back('{due: cyc + dly, val: v, tag: tag});
  endtask
  task automatic expc(input int dly, input logic v, input int tag);
    qc.push_back('{due: cyc + dly, val: {{(DWID-1){1'b0}}, v}, tag: tag});
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic idle();
    ena_i = 0; wea_i = '0; enb_i = 0; web_i = '0; regcea_i = 1;
  endtask

  task automatic a_wr(input logic [AW-1:0] a, input logic [DWID-1:0] d, input logic [NSEL-1:0] s);
    ena_i = 1; wea_i = s; addra_i = a; dina_i = d;
  endtask
  task automatic a_rd(input logic [AW-1:0] a);
    ena_i = 1; wea_i = '0; addra_i = a;
  endtask
  task automatic b_wr(input logic [AW-1:0] a, input logic [DWID-1:0] d, input logic [NSEL-1:0] s);
    enb_i = 1; web_i = s; addrb_i = a; dinb_i = d;
  endtask
  task automatic b_rd(input logic [AW-1:0] a);
    enb_i = 1; web_i = '0; addrb_i = a;
  endtask

  localparam logic [DWID-1:0] W5   = 64'h0123_4567_89AB_CDEF;
  localparam logic [DWID-1:0] W5B  = 64'h0123_4567_FFFF_FFFF;
  localparam logic [DWID-1:0] W7   = 64'hAAAA_BBBB_0000_0000;

  initial begin
    idle();
    addra_i = '0; addrb_i = '0; dina_i = '0; dinb_i = '0;
    rst_ni = 0;
    step(); step(); step();
    chk("rst_douta", 0, douta_o, 64'h0);
    chk("rst_doutb", 0, doutb_o, 64'h0);
    rst_ni = 1;
    step();

    // initial contents
    a_rd(0); b_rd(0); expa(2, 64'h0, 1); expb(1, 64'h0, 1); step();
    idle(); step(); step();

    // port A full write then 2-cycle read
    a_wr(5, W5, 8'hFF); step();
    a_rd(5); expa(1, 64'h0, 2); expa(2, W5, 3); step();
    idle(); step(); step();

    // port B byte-enable merge
    b_wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); step();
    idle(); b_rd(5); expb(1, W5B, 4); step();
    idle(); step();

    // cross-port read-first, both directions
    a_wr(14'h3FFF, 64'h11, 8'hFF); step();
    a_wr(14'h3FFF, 64'h22, 8'hFF); b_rd(14'h3FFF); expb(1, 64'h11, 5); step();
    idle(); b_rd(14'h3FFF); expb(1, 64'h22, 6); step();
    idle(); b_wr(14'h3FFF, 64'h33, 8'hFF); a_rd(14'h3FFF); expa(2, 64'h22, 7); step();
    idle(); b_rd(14'h3FFF); expb(1, 64'h33, 8); step();
    idle(); step();

    // dual-write collision merge
    a_wr(7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0);
    b_wr(7, 64'hBBBB_BBBB_BBBB_BBBB, 8'h30);
    expc(1, 1'b1, 9); expc(2, 1'b0, 10);
    step();
    idle(); a_rd(7); b_rd(7); expb(1, W7, 11); expa(2, W7, 12); step();
    idle(); step(); step();

    // enable/hold behaviour
    a_rd(14'h3FFF); b_rd(5); expb(1, W5B, 13); expa(2, 64'h33, 14); step();
    idle(); step(); step();
    idle(); addra_i = 7; addrb_i = 7;
    expa(1, 64'h33, 15); expa(2, 64'h33, 16); expb(1, W5B, 17); expb(2, W5B, 18);
    step(); step();
    a_wr(9, 64'h5555, 8'hFF); expa(1, 64'h33, 19); expa(2, 64'h33, 20); step();
    idle(); b_rd(9); expb(1, 64'h5555, 21); step();
    idle(); a_rd(5); expa(1, 64'h33, 22); expa(2, 64'h33, 23); expa(3, W5B, 24); step();
    idle(); regcea_i = 0; step();
    idle(); step(); step();

    // asynchronous reset mid-operation; writes suppressed while held
    a_wr(5, 64'h0, 8'hFF);
    #2 rst_ni = 0;
    #1;
    chk("midrst_douta", 25, douta_o, 64'h0);
    chk("midrst_doutb", 26, doutb_o, 64'h0);
    step(); step();
    rst_ni = 1;
    idle(); step();
    a_rd(5); b_rd(5); expb(1, W5B, 27); expa(1, 64'h0, 28); expa(2, W5B, 29); step();
    idle(); step(); step(); step();

    if (qa.size() != 0 || qb.size() != 0
`ifdef TDPRAM_COLLISION_FLAG_EN
        || qc.size() != 0
`endif
       ) begin
      total++;
      bad++;
      $display("FAIL drain leftover qa=%0d qb=%0d qc=%0d want 0", qa.size(), qb.size(), qc.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
